// File: rtl/vector_component_serializer.sv
// vector_component_serializer: accepts a packed vector plus a component
// enable mask, then emits the enabled components one per beat, lowest
// index first. A zero-mask vector is accepted and reported on out_drop.
module vector_component_serializer #(
  parameter int COMP_WIDTH = 16,
  parameter int NUM_COMPS  = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_COMPS*COMP_WIDTH-1:0] in_vector_val,
  input  logic [NUM_COMPS-1:0]            in_mask,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COMP_WIDTH-1:0]           out_component,
  output logic [IDX_WIDTH-1:0]            out_index,
  output logic                            out_last,
  output logic                            out_drop
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                           state_q, state_d;
  logic [NUM_COMPS-1:0][COMP_WIDTH-1:0] data_q, data_d;
  logic [NUM_COMPS-1:0]                 mask_q, mask_d;
  logic                                 drop_q, drop_d;

  logic [NUM_COMPS-1:0] low_bit;
  logic [IDX_WIDTH-1:0] low_idx;
  logic                 one_left;
  logic                 busy;
  logic                 accept;
  logic                 emit;

  assign busy     = (state_q == BUSY);
  // Isolate the lowest pending component; one_left means it is the final one.
  assign low_bit  = mask_q & (~mask_q + 1'b1);
  assign one_left = (mask_q != '0) && ((mask_q & (mask_q - 1'b1)) == '0);

  // Priority encode the lowest pending component index.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_COMPS - 1; k >= 0; k--) begin
      if (mask_q[k]) low_idx = IDX_WIDTH'(k);
    end
  end

  assign out_valid     = busy;
  assign out_last      = busy & one_left;
  assign out_index     = busy ? low_idx : '0;
  assign out_component = busy ? data_q[low_idx] : '0;
  assign out_drop      = drop_q;
  // Taking a new vector on the last beat keeps back-to-back vectors bubble free.
  assign in_ready      = !busy || (one_left && out_ready);

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Next-state: load on accept, retire the lowest pending bit on each emit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    drop_d  = 1'b0;
    if (!busy) begin
      if (accept) begin
        if (in_mask != '0) begin
          data_d  = in_vector_val;
          mask_d  = in_mask;
          state_d = BUSY;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else if (emit) begin
      if (!one_left) begin
        mask_d = mask_q & ~low_bit;
      end else if (accept && (in_mask != '0)) begin
        data_d = in_vector_val;
        mask_d = in_mask;
      end else begin
        state_d = IDLE;
        mask_d  = '0;
        drop_d  = accept;
      end
    end
  end

  // State registers; reset discards any vector in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
    end
  end

endmodule
